// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer datapath: FP32 field
// positions and the packer state encoding.
package fc_pkg;

  localparam int FP32_SIGN_BIT = 31;
  localparam int FP32_EXP_MSB  = 30;
  localparam int FP32_EXP_LSB  = 23;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } pack_state_e;

endpackage : fc_pkg

// File: rtl/fp32_ftz.sv
// Flush-to-zero for one FP32 word: a zero exponent field (denormal or zero)
// becomes a signed zero. Purely combinational, reusable by processing elements.
module fp32_ftz
  import fc_pkg::*;
(
  input  logic [31:0] in_word,
  output logic [31:0] out_word
);

  always_comb begin
    out_word = in_word;
    if (in_word[FP32_EXP_MSB:FP32_EXP_LSB] == '0) begin
      out_word = {in_word[FP32_SIGN_BIT], 31'b0};
    end
  end

endmodule : fp32_ftz

// File: rtl/fc_vector_packer.sv
// Serial-to-parallel packer: fills out_vector from slot INPUT_NODES-1 downward.
// Optional input flush-to-zero when FC_PACK_FTZ_EN is defined (DATA_WIDTH=32 only).
module fc_vector_packer
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int INPUT_NODES = 100
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_valid,
  input  logic                              in_last,
  output logic                              in_ready,
  output logic [DATA_WIDTH*INPUT_NODES-1:0] out_vector,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(INPUT_NODES+1)-1:0]  fill_count
);

  localparam int IDX_W = $clog2(INPUT_NODES);
  localparam int CNT_W = $clog2(INPUT_NODES + 1);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(INPUT_NODES - 1);

  pack_state_e                        state_q, state_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic [DATA_WIDTH*INPUT_NODES-1:0]  vec_q, vec_d;
  logic                               out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]              word_in;

`ifdef FC_PACK_FTZ_EN
  fp32_ftz u_ftz (
    .in_word  (in_data),
    .out_word (word_in)
  );
`else
  assign word_in = in_data;
`endif

  // Held low during reset so no upstream word is considered taken.
  assign in_ready = (state_q == FILL) && !reset;

  always_comb begin
    // NOTE: every target gets a hold default first, so no path leaves it unassigned (no latch).
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    vec_d       = vec_q;
    out_valid_d = out_valid_q;
    case (state_q)
      FILL: begin
        if (in_valid && in_ready) begin
          vec_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = word_in;
          cnt_d = cnt_q + CNT_W'(1);
          // idx never decrements past 0: that accept always ends the fill.
          if (idx_q == '0 || in_last) begin
            state_d     = FULL;
            out_valid_d = 1'b1;
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end
      end
      FULL: begin
        if (out_ready) begin
          state_d     = FILL;
          idx_d       = IDX_TOP;
          cnt_d       = '0;
          vec_d       = '0;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // NOTE: the vector is a flop bank, not a RAM, so resetting it is cheap and
  // guarantees unwritten slots of a short vector read as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      idx_q       <= IDX_TOP;
      cnt_q       <= '0;
      vec_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      vec_q       <= vec_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_vector = vec_q;
  assign out_valid  = out_valid_q;
  assign fill_count = cnt_q;

endmodule : fc_vector_packer

// File: tb/tb_fc_vector_packer.sv
// Directed self-checking bench for fc_vector_packer with INPUT_NODES=4.
// Expected FTZ results follow FC_PACK_FTZ_EN as defined for the build.
module tb_fc_vector_packer;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic [DW-1:0]     in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [DW*N-1:0]   out_vector;
  logic              out_valid;
  logic              out_ready;
  logic [CW-1:0]     fill_count;

  int n_checks = 0;
  int n_errors = 0;

  fc_vector_packer #(.DATA_WIDTH(DW), .INPUT_NODES(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_vector (out_vector),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fill_count (fill_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW*N-1:0] got, input logic [DW*N-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] slot(input int k);
    return out_vector[DW*k +: DW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [DW-1:0] words_a [N] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  logic [DW-1:0] words_b [N] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  logic [DW*N-1:0] snap;
  logic [DW-1:0]   ftz_exp;

  initial begin
    reset = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_in_ready",   128'(in_ready),   128'(0));
    check("rst_out_valid",  128'(out_valid),  128'(0));
    check("rst_fill_count", 128'(fill_count), 128'(0));
    check("rst_vector",     out_vector,       '0);
    reset = 1'b0;
    tick();
    check("post_rst_in_ready", 128'(in_ready), 128'(1));

    // Full fill on consecutive cycles
    in_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_data = words_a[i];
      tick();
      check("fill_count_step", 128'(fill_count), 128'(i + 1));
      if (i == N - 2) check("no_early_valid", 128'(out_valid), 128'(0));
    end
    in_valid = 1'b0;
    check("full_out_valid", 128'(out_valid), 128'(1));
    check("full_in_ready",  128'(in_ready),  128'(0));
    check("full_slot3",     128'(slot(3)),   128'(32'h3F800000));
    check("full_slot2",     128'(slot(2)),   128'(32'h40000000));
    check("full_slot1",     128'(slot(1)),   128'(32'h40400000));
    check("full_slot0",     128'(slot(0)),   128'(32'h40800000));

    // Backpressure: new data offered while FULL must be ignored
    snap = {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 32'hDEAD0000 | 32'(i);
      tick();
    end
    in_valid = 1'b0;
    check("bp_vector",     out_vector,       snap);
    check("bp_fill_count", 128'(fill_count), 128'(4));
    check("bp_out_valid",  128'(out_valid),  128'(1));
    drain();
    check("drain_out_valid",  128'(out_valid),  128'(0));
    check("drain_vector",     out_vector,       '0);
    check("drain_in_ready",   128'(in_ready),   128'(1));
    check("drain_fill_count", 128'(fill_count), 128'(0));

    // out_ready while FILL is ignored
    out_ready = 1'b1;
    send(32'hAAAAAAAA, 1'b0);
    out_ready = 1'b0;
    send(32'hBBBBBBBB, 1'b1);
    check("short_out_valid",  128'(out_valid),  128'(1));
    check("short_fill_count", 128'(fill_count), 128'(2));
    check("short_vector",     out_vector, {32'hAAAAAAAA, 32'hBBBBBBBB, 64'h0});
    drain();

    // Gapped input: valid on odd cycles only
    begin
      int k = 0;
      for (int c = 1; c <= 7; c++) begin
        in_valid = c[0];
        in_data  = c[0] ? words_b[k] : 32'hFFFFFFFF;
        tick();
        if (c[0]) k++;
        if (c == 4) check("gap_count_c4", 128'(fill_count), 128'(2));
        if (c == 6) check("gap_not_full_c6", 128'(out_valid), 128'(0));
      end
      in_valid = 1'b0;
    end
    check("gap_full_c7", 128'(out_valid), 128'(1));
    check("gap_vector",  out_vector, {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444});
    drain();

    // Reset between edges mid-fill
    send(32'h55555555, 1'b0);
    send(32'h66666666, 1'b0);
    check("mid_fill_count", 128'(fill_count), 128'(2));
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_vector",   out_vector,       '0);
    check("async_rst_count",    128'(fill_count), 128'(0));
    check("async_rst_in_ready", 128'(in_ready),   128'(0));
    check("async_rst_valid",    128'(out_valid),  128'(0));
    tick();
    reset = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_data = words_b[N - 1 - i];
      tick();
    end
    in_valid = 1'b0;
    check("refill_valid",  128'(out_valid),  128'(1));
    check("refill_count",  128'(fill_count), 128'(4));
    check("refill_vector", out_vector, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
    drain();

    // Flush-to-zero behaviour
`ifdef FC_PACK_FTZ_EN
    ftz_exp = 32'h80000000;
`else
    ftz_exp = 32'h807FFFFF;
`endif
    send(32'h807FFFFF, 1'b0);
    send(32'h00800000, 1'b1);
    check("ftz_denorm", 128'(slot(3)), 128'(ftz_exp));
    check("ftz_normal", 128'(slot(2)), 128'(32'h00800000));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fc_vector_packer

// File: doc/fc_vector_packer.md
# fc_vector_packer

Serial-to-parallel packer at the input side of a fully-connected layer: accepts one DATA_WIDTH word per cycle on a valid/ready stream and assembles an INPUT_NODES-wide vector for the next layer's `input_fc` port. This is the writer for the layer's serial input selector. The first word received lands in the highest slot, index INPUT_NODES-1, and later words fill downward to index 0. The selector downstream issues words in that same descending order.

## Interface
- DATA_WIDTH, 32, width of one float32 word
- INPUT_NODES, 100, number of words per vector (≥2)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_data  input  DATA_WIDTH  serial word
- in_valid  input  1  in_data valid
- in_last  input  1  marks final word of a short vector (qualified by in_valid)
- in_ready  output  1  packer can accept a word this cycle
- out_vector  output  DATA_WIDTH*INPUT_NODES  packed vector; slot k = out_vector[DATA_WIDTH*k +: DATA_WIDTH]
- out_valid  output  1  out_vector complete and stable
- out_ready  input  1  consumer takes out_vector
- fill_count  output  $clog2(INPUT_NODES+1)  words accepted into the current vector

## Operation
- Two states: FILL and FULL.
- **FILL**
  - in_ready = 1.
  - A word is accepted when in_valid && in_ready.
  - An accepted word is written to slot idx. idx then decrements and fill_count increments.
  - Transition to FULL on accepting the word at idx==0.
  - Also transition to FULL on accepting any word with in_last=1. Slots not written remain 0.
  - in_last on the idx==0 word is legal and gives the same result as without it.
- **FULL**
  - in_ready = 0 and out_valid = 1.
  - out_vector and fill_count are held stable.
  - On out_valid && out_ready:
    - clear all slots to 0;
    - set fill_count = 0 and idx = INPUT_NODES-1;
    - return to FILL.
- in_valid while in FULL is ignored: no write and no error.
- out_ready while in FILL is ignored.
- in_ready is combinational from state, forced to 0 while reset is high. out_valid is registered.
- Words are stored bit-exact, except as modified by the configuration option below.
- There is no arithmetic besides idx/fill_count. idx is $clog2(INPUT_NODES) bits and never wraps below 0, because reaching idx==0 forces FULL.
- **Reset** (asynchronous, any state, including mid-fill): returns to FILL, discarding partial data.
  - out_vector = 0, out_valid = 0, fill_count = 0, idx = INPUT_NODES-1.
  - in_ready = 0 during reset, 1 from the first clk edge after release.

## Timing
- A word accepted at edge t is visible in out_vector and fill_count after edge t.
- out_valid rises after the edge that accepts the final word. Latency from last accept to out_valid is 1 cycle.
- Full vector with continuous in_valid: INPUT_NODES accept cycles, then FULL.
- FULL lasts at least 1 cycle, ending at the edge where out_ready=1.
- in_ready returns to 1 in the cycle after the out handshake. Minimum period per vector is INPUT_NODES+1 cycles.
- No combinational path from in_valid or out_ready to any output.

## Configuration
- `FC_PACK_FTZ_EN` defined: flush-to-zero on input, valid only for DATA_WIDTH=32.
  - Any accepted word with exponent bits [30:23]==0 is stored as {in_data[31], 31'b0}.
  - This covers denormals and both zeros. The sign is preserved.
- Undefined: all words are stored unmodified.
- Timing is identical in both builds.

## Structure
- Shared package `fc_pkg` holds:
  - FP32 field constants: FP32_SIGN_BIT=31, FP32_EXP_MSB=30, FP32_EXP_LSB=23;
  - the state enum {FILL, FULL}.
- One natural sub-module, `fp32_ftz`: combinational word in, word out.
  - Instantiated only under `FC_PACK_FTZ_EN`.
  - Reusable by the layer's processing elements.
- Everything else stays in `fc_vector_packer`.

## Test plan
Use INPUT_NODES=4, DATA_WIDTH=32 unless noted.
- **Full fill:** words 0x3F800000, 0x40000000, 0x40400000, 0x40800000 on consecutive cycles → out_valid after the 4th edge; slot3=0x3F800000, slot0=0x40800000; fill_count=4; in_ready=0.
- **Backpressure:** hold out_ready=0 for 10 cycles in FULL while in_valid=1 with new data → out_vector unchanged, no accepts. Then out_ready=1 for 1 cycle → next cycle out_valid=0, out_vector=0, in_ready=1.
- **Short vector:** 2 words 0xAAAAAAAA, 0xBBBBBBBB (in_last on the 2nd) → slot3=0xAAAAAAAA, slot2=0xBBBBBBBB, slots1..0=0, fill_count=2.
- **Gapped input:** in_valid toggling 1/0 → only valid cycles are counted; FULL after the 4th valid word at cycle 7.
- **Reset mid-fill:** after 2 accepts, pulse reset between clk edges → outputs 0 immediately. A fresh 4-word fill then completes correctly with no stale data.
- **FTZ build:** word 0x807FFFFF → with `FC_PACK_FTZ_EN` stored as 0x80000000; without it stored as 0x807FFFFF. 0x00800000 is unchanged in both builds.
